ifetch_unit: RTL and testbench

//  Instruction fetch stage of the RISC-V CPU, directly upstream of decode / immediate generation.

---
 rtl/ifetch_unit_pkg.sv | 15 +
 rtl/ifetch_unit_if.sv | 15 +
 rtl/ifetch_unit_fetch_fifo.sv | 67 ++++++
 rtl/ifetch_unit.sv | 97 +++++++++
 tb/tb_ifetch_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: data widths, reset PC
// and the {pc, ins} fetch-packet layout used by the fetch buffer.
package ifetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int PKT_INS_LSB = 0;
  localparam int PKT_PC_LSB  = ILEN;
  localparam int PKT_W       = XLEN + ILEN;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus: req/gnt request phase, in-order rvalid response phase.
// Handshake: a request transfers in a cycle where imem_req & imem_gnt; each
// transferred request gets exactly one imem_rvalid pulse, in order, at least one cycle later.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// Synchronous fetch buffer with push, pop, clear, occupancy count and a head
// view that reads as zero while empty.
module ifetch_unit_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Clear wins over both push and pop in the same cycle.
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && (count_q == CNT_W'(DEPTH))));
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, request credit, stale-response discard after
// redirects, and a fetch buffer presented to decode via valid/ready.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4,
  parameter int              CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  input  logic                redir_valid,
  input  logic [XLEN-1:0]     redir_pc,
  ifetch_unit_if.master       imem,
  output logic                ins_valid,
  input  logic                ins_ready,
  output logic [ILEN-1:0]     ins,
  output logic [XLEN-1:0]     ins_pc
);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d, resp_pc_q, resp_pc_d, target;
  logic [CNT_W-1:0] outst_q, outst_d, discard_q, discard_d, fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             grant, rv_live, push, pop;
  logic [PKT_W-1:0] push_pkt, head_pkt;

  assign target      = word_align(redir_pc);
  assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};

  // Buffered plus in-flight words never exceed the buffer depth.
  assign imem.imem_req  = rst_n & fetch_en & ~redir_valid & (credit_used < DEPTH_C);
  assign imem.imem_addr = pc_q;
  assign grant          = imem.imem_req & imem.imem_gnt;
  // A response with nothing outstanding predates a reset and is ignored.
  assign rv_live        = imem.imem_rvalid & (outst_q != '0);
  assign pop            = ins_valid & ins_ready & ~redir_valid;
  assign push_pkt       = {resp_pc_q, imem.imem_rdata};

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q + CNT_W'(grant) - CNT_W'(rv_live);
    discard_d = discard_q;
    push      = 1'b0;
    if (redir_valid) begin
      pc_d      = target;
      resp_pc_d = target;
      // Everything still pending after this cycle belongs to the old path.
      discard_d = outst_q - CNT_W'(rv_live);
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (rv_live) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CNT_W'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  ifetch_unit_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PKT_W),
    .CNT_W (CNT_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .clear     (redir_valid),
    .count     (fifo_count),
    .head      (head_pkt)
  );

  assign ins_valid = (fifo_count != '0);
  assign ins       = head_pkt[PKT_INS_LSB +: ILEN];
  assign ins_pc    = head_pkt[PKT_PC_LSB +: XLEN];
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: randomized memory/decode behaviour checked against a
// request/epoch reference model, plus directed redirect, wrap and reset scenarios.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        ins_ready = 1'b0;
  logic        ins_valid;
  logic [31:0] ins, ins_pc;

  ifetch_unit_if imem();

  ifetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .imem(imem), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins(ins), .ins_pc(ins_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // reference model state
  int          errors = 0, checks = 0;
  logic [63:0] exp_q[$];      // {pc, ins} packets decode should see, in order
  logic [47:0] pend_q[$];     // {epoch, addr} of granted, unanswered requests
  logic [15:0] epoch;
  logic [31:0] model_pc;
  logic [31:0] popped_pc_q[$];
  int          grant_cnt;
  int          gnt_pct, rv_pct, rdy_pct;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redir_valid = 1'b0; ins_ready = 1'b0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    exp_q.delete(); pend_q.delete(); popped_pc_q.delete();
    epoch = '0; model_pc = 32'h0; grant_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive memory/decode, check against the model, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc);
    logic        exp_req, grant, rv, pop;
    logic [47:0] e;
    logic [63:0] p;
    e = '0;
    redir_valid   = redir;
    redir_pc      = rpc;
    imem.imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    ins_ready     = ($urandom_range(0, 99) < rdy_pct);
    rv = (pend_q.size() != 0) && ($urandom_range(0, 99) < rv_pct);
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? word_of(pend_q[0][31:0]) : $urandom();
    @(negedge clk);
    exp_req = fetch_en && !redir && (pend_q.size() + exp_q.size() < DEPTH);
    checks++;
    if (imem.imem_req !== exp_req) begin
      errors++; $display("FAIL imem_req t=%0t got %b exp %b", $time, imem.imem_req, exp_req);
    end
    checks++;
    if (imem.imem_addr !== model_pc) begin
      errors++; $display("FAIL imem_addr t=%0t got %h exp %h", $time, imem.imem_addr, model_pc);
    end
    checks++;
    if (ins_valid !== (exp_q.size() != 0)) begin
      errors++; $display("FAIL ins_valid t=%0t got %b exp %b", $time, ins_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      checks++;
      if ({ins_pc, ins} !== exp_q[0]) begin
        errors++; $display("FAIL packet t=%0t got %h/%h exp %h/%h", $time, ins_pc, ins,
                           exp_q[0][63:32], exp_q[0][31:0]);
      end
    end
    obs_req = imem.imem_req; obs_addr = imem.imem_addr; obs_valid = ins_valid; obs_pc = ins_pc;
    grant = exp_req && imem.imem_gnt;
    pop   = (exp_q.size() != 0) && ins_ready;
    @(posedge clk);
    if (rv) e = pend_q.pop_front();
    if (redir) begin
      model_pc = {rpc[31:2], 2'b00};
      epoch++;
      exp_q.delete();
    end else begin
      if (pop) begin
        p = exp_q.pop_front();
        popped_pc_q.push_back(p[63:32]);
      end
      if (rv && e[47:32] == epoch) exp_q.push_back({e[31:0], word_of(e[31:0])});
      if (grant) begin
        pend_q.push_back({epoch, model_pc});
        model_pc += 32'd4;
        grant_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0;
    #3;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ins_valid); end
    checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem.imem_req); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL rst_ins got %h exp 0", ins); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL rst_ins_pc got %h exp 0", ins_pc); end
    checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem.imem_addr); end
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    repeat (20) step(1'b0, '0);
    checks++;
    if (popped_pc_q.size() != 18) begin
      errors++; $display("FAIL stream_count got %0d exp 18", popped_pc_q.size());
    end
    for (int i = 0; i < popped_pc_q.size(); i++) begin
      checks++;
      if (popped_pc_q[i] !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, popped_pc_q[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (10) step(1'b0, '0);
    checks++; if (grant_cnt != 4) begin errors++; $display("FAIL bp_grants got %0d exp 4", grant_cnt); end
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", obs_req); end
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", obs_valid); end
    checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL bp_pc got %h exp 0", obs_pc); end
  endtask

  task automatic test_redirect();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
    repeat (2) step(1'b0, '0);
    step(1'b1, 32'h0000_0103);
    popped_pc_q.delete();
    rv_pct = 100;
    step(1'b0, '0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
      errors++; $display("FAIL redir_addr got req=%b addr=%h exp req=1 addr=100", obs_req, obs_addr);
    end
    repeat (8) step(1'b0, '0);
    checks++;
    if (popped_pc_q.size() < 1 || popped_pc_q[0] !== 32'h100) begin
      errors++; $display("FAIL redir_first_pc got %h (n=%0d) exp 100",
                         popped_pc_q.size() ? popped_pc_q[0] : 32'h0, popped_pc_q.size());
    end
  endtask

  task automatic test_redir_collision();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rdy_pct = 0; rv_pct = 100;
    repeat (2) step(1'b0, '0);
    rv_pct = 0;
    repeat (2) step(1'b0, '0);
    rv_pct = 100; rdy_pct = 100;
    step(1'b1, 32'h0000_0200);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL coll_pop_valid got %b exp 1", obs_valid); end
    popped_pc_q.delete();
    step(1'b0, '0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL coll_empty got %b exp 0", obs_valid); end
    repeat (10) step(1'b0, '0);
    checks++;
    if (popped_pc_q.size() < 1 || popped_pc_q[0] !== 32'h200) begin
      errors++; $display("FAIL coll_first_pc got %h (n=%0d) exp 200",
                         popped_pc_q.size() ? popped_pc_q[0] : 32'h0, popped_pc_q.size());
    end
  endtask

  task automatic test_fetch_en_off();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 0; rdy_pct = 100;
    repeat (2) step(1'b0, '0);
    fetch_en = 1'b0; rv_pct = 100;
    popped_pc_q.delete();
    repeat (6) step(1'b0, '0);
    checks++; if (grant_cnt != 2) begin errors++; $display("FAIL fe_grants got %0d exp 2", grant_cnt); end
    checks++;
    if (popped_pc_q.size() != 2 || popped_pc_q[0] !== 32'h0 || popped_pc_q[1] !== 32'h4) begin
      errors++; $display("FAIL fe_order got n=%0d exp 2 packets 0,4", popped_pc_q.size());
    end
    checks++; if (obs_addr !== 32'h8) begin errors++; $display("FAIL fe_pc_hold got %h exp 8", obs_addr); end
  endtask

  task automatic test_wrap();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    step(1'b1, 32'hFFFF_FFFE);
    popped_pc_q.delete();
    step(1'b0, '0);
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top got req=%b addr=%h exp req=1 addr=fffffffc", obs_req, obs_addr);
    end
    step(1'b0, '0);
    checks++; if (obs_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", obs_addr); end
    repeat (6) step(1'b0, '0);
    checks++;
    if (popped_pc_q.size() < 2 || popped_pc_q[0] !== 32'hFFFF_FFFC || popped_pc_q[1] !== 32'h0) begin
      errors++; $display("FAIL wrap_pcs got n=%0d exp fffffffc then 0", popped_pc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    fetch_en = 1'b1; gnt_pct = 100; rv_pct = 100; rdy_pct = 0;
    repeat (5) step(1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", ins_valid); end
    checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", imem.imem_req); end
    checks++; if ({ins_pc, ins} !== 64'h0) begin errors++; $display("FAIL mid_payload got %h/%h exp 0/0", ins_pc, ins); end
    checks++; if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_pc got %h exp 0", imem.imem_addr); end
    exp_q.delete(); pend_q.delete(); popped_pc_q.delete();
    epoch = '0; model_pc = 32'h0; grant_cnt = 0;
    fetch_en = 1'b0; imem.imem_gnt = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 imem.imem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL late_rvalid got valid=%b exp 0", ins_valid); end
    @(posedge clk);
    #1;
    fetch_en = 1'b1; rv_pct = 100; rdy_pct = 100;
    repeat (6) step(1'b0, '0);
    checks++;
    if (popped_pc_q.size() < 1 || popped_pc_q[0] !== 32'h0) begin
      errors++; $display("FAIL mid_restart got n=%0d exp first pc 0", popped_pc_q.size());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        gnt_pct  = $urandom_range(30, 100);
        rv_pct   = $urandom_range(20, 100);
        rdy_pct  = $urandom_range(0, 100);
        fetch_en = ($urandom_range(0, 9) < 8);
      end
      step($urandom_range(0, 99) < 4, $urandom());
    end
    fetch_en = 1'b0; rv_pct = 100; rdy_pct = 100;
    repeat (20) step(1'b0, '0);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got valid=%b exp 0", obs_valid); end
  endtask

  initial begin
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    gnt_pct = 0; rv_pct = 0; rdy_pct = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redir_collision();
    test_fetch_en_off();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
